// File: rtl/lm_sm_sequencer.sv
// ---------------------------------------------------------------------------
// lm_sm_sequencer
//
// Multi-cycle sequencer for load-multiple (LM) and store-multiple (SM).
// A launch latches an 8-bit register list, a 16-bit base word address and
// the transfer direction. The block then steps through the set bits of the
// list, lowest first, and performs one transfer per cycle. A transfer is
// held off for as long as memory reports that it is not ready.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   start     in   launch a sequence (sampled only while idle)
//   isLoad    in   1 = LM (memory -> registers), 0 = SM (registers -> memory)
//   regList   in   [7:0]  bit i set = transfer register Ri
//   baseAddr  in   [15:0] memory word address of the first transfer
//   hold      in   memory-not-ready stall; freezes the sequencer
//   busy      out  high whenever a sequence is in progress
//   regAdd    out  [2:0]  register index of the current transfer
//   memAdd    out  [15:0] memory word address of the current transfer
//   regWrite  out  register-file write strobe (LM transfers)
//   memWrite  out  data-memory write strobe (SM transfers)
//   pcWrite   out  current LM transfer writes R7; control must flush
//   done      out  one-cycle completion pulse
//
// The outputs are decoded from registered state plus the live hold input:
// the register file and memory capture on the edge that ends a transfer
// cycle, so the strobes must drop in the same cycle that hold rises.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module lm_sm_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        isLoad,
  input  logic [7:0]  regList,
  input  logic [15:0] baseAddr,
  input  logic        hold,
  output logic        busy,
  output logic [2:0]  regAdd,
  output logic [15:0] memAdd,
  output logic        regWrite,
  output logic        memWrite,
  output logic        pcWrite,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic [7:0]  pending_q;
  logic [3:0]  offset_q;
  logic [15:0] base_q;
  logic        load_q;

  logic [7:0]  pending_d;
  logic [3:0]  offset_d;
  logic [2:0]  low_idx_s;
  logic        xfer_s;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        idx = i[2:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Values that a completed (non-held) transfer advances to.
  always_comb begin
    // v & (v - 1) clears exactly the lowest set bit, i.e. the one being transferred
    pending_d = pending_q & (pending_q - 8'd1);
    offset_d  = offset_q + 4'd1;
    low_idx_s = lowest_set(pending_q);
    xfer_s    = (state_q == S_XFER);
  end

  // Sequencer state machine and its working registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pending_q <= 8'd0;
      offset_q  <= 4'd0;
      base_q    <= 16'd0;
      load_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pending_q <= regList;
            base_q    <= baseAddr;
            load_q    <= isLoad;
            offset_q  <= 4'd0;
            state_q   <= (regList != 8'd0) ? S_XFER : S_DONE;
          end
        end
        S_XFER: begin
          if (!hold) begin
            pending_q <= pending_d;
            offset_q  <= offset_d;
            if (pending_d == 8'd0) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode: addresses only during a transfer, strobes gated by hold.
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    regAdd   = 3'd0;
    memAdd   = 16'd0;
    regWrite = 1'b0;
    memWrite = 1'b0;
    pcWrite  = 1'b0;
    if (xfer_s) begin
      regAdd   = low_idx_s;
      // 16-bit add wraps naturally past 0xFFFF
      memAdd   = base_q + {12'd0, offset_q};
      regWrite = load_q & ~hold;
      memWrite = ~load_q & ~hold;
      pcWrite  = load_q & ~hold & (low_idx_s == 3'd7);
    end else begin
      regAdd   = 3'd0;
      memAdd   = 16'd0;
    end
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
`timescale 1ns/1ps

module tb_lm_sm_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        isLoad;
  logic [7:0]  regList;
  logic [15:0] baseAddr;
  logic        hold;
  logic        busy;
  logic [2:0]  regAdd;
  logic [15:0] memAdd;
  logic        regWrite;
  logic        memWrite;
  logic        pcWrite;
  logic        done;

  lm_sm_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .isLoad   (isLoad),
    .regList  (regList),
    .baseAddr (baseAddr),
    .hold     (hold),
    .busy     (busy),
    .regAdd   (regAdd),
    .memAdd   (memAdd),
    .regWrite (regWrite),
    .memWrite (memWrite),
    .pcWrite  (pcWrite),
    .done     (done)
  );

  typedef struct packed {
    logic        is_done;
    logic        wr_reg;
    logic        wr_mem;
    logic        pc;
    logic [2:0]  ra;
    logic [15:0] ma;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_act;
  ev_t mon_exp;
  int  checks = 0;
  int  errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one event per set bit, lowest first, then a done event.
  task automatic push_expected(input logic ld, input logic [7:0] lst, input logic [15:0] bs);
    ev_t e;
    int  n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (lst[i]) begin
        e.is_done = 1'b0;
        e.wr_reg  = ld;
        e.wr_mem  = !ld;
        e.pc      = ld && (i == 7);
        e.ra      = i[2:0];
        e.ma      = bs + 16'(n);
        exp_q.push_back(e);
        n++;
      end
    end
    e = '0;
    e.is_done = 1'b1;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe or done pulse must match the next expected event.
  always @(negedge clk) begin
    if (reset && (regWrite || memWrite || done)) begin
      mon_act.is_done = done;
      mon_act.wr_reg  = regWrite;
      mon_act.wr_mem  = memWrite;
      mon_act.pc      = pcWrite;
      mon_act.ra      = (regWrite || memWrite) ? regAdd : 3'd0;
      mon_act.ma      = (regWrite || memWrite) ? memAdd : 16'd0;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event actual=%h expected=none at %0t", mon_act, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL event actual=%h expected=%h at %0t", mon_act, mon_exp, $time);
        end
      end
    end
  end

  // One sequence; entered away from the clock edge while the DUT is idle.
  task automatic run_seq(input logic ld, input logic [7:0] lst, input logic [15:0] bs,
                         input logic [31:0] hpat, input bit rnd, input bit midstart);
    int   remaining;
    int   c;
    bit   seen_done;
    logic h;
    start = 1'b1; isLoad = ld; regList = lst; baseAddr = bs; hold = 1'b0;
    push_expected(ld, lst, bs);
    remaining = $countones(lst);
    @(posedge clk); #1;
    start = 1'b0; isLoad = 1'($urandom); regList = 8'($urandom); baseAddr = 16'($urandom);
    c = 0;
    seen_done = 1'b0;
    while (!seen_done && c < 64) begin
      h = rnd ? ($urandom_range(0, 3) == 0) : hpat[c % 32];
      hold = h;
      start = (midstart && c == 1) ? 1'b1 : 1'b0;
      @(negedge clk);
      chk("busy_in_seq", busy, 1);
      chk("done_timing", done, remaining == 0);
      chk("strobe_timing", regWrite | memWrite, (remaining > 0) && !h);
      if (remaining == 0) seen_done = 1'b1;
      else if (!h) remaining--;
      @(posedge clk); #1;
      c++;
    end
    hold = 1'b0;
    start = 1'b0;
    if (!seen_done) begin
      errors++;
      $display("FAIL seq_timeout actual=no_done expected=done at %0t", $time);
    end
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_after_done", done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; isLoad = 1'b0; regList = 8'd0; baseAddr = 16'd0; hold = 1'b0;
    #1;
    chk("reset_outputs", {busy, regAdd, memAdd, regWrite, memWrite, pcWrite, done}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {busy, done}, 0);

    // Directed cases
    run_seq(1'b1, 8'h25, 16'h0100, 32'd0, 1'b0, 1'b0);
    run_seq(1'b0, 8'hFF, 16'hFFFE, 32'd0, 1'b0, 1'b0);
    run_seq(1'b1, 8'h80, 16'h0040, 32'd0, 1'b0, 1'b0);
    run_seq(1'b0, 8'h00, 16'h1234, 32'd0, 1'b0, 1'b0);
    run_seq(1'b0, 8'h06, 16'h0300, 32'd3, 1'b0, 1'b1);

    // Reset mid-sequence: LM 0xF0, abort during the second transfer
    start = 1'b1; isLoad = 1'b1; regList = 8'hF0; baseAddr = 16'h1234;
    exp_q.push_back('{is_done: 1'b0, wr_reg: 1'b1, wr_mem: 1'b0, pc: 1'b0, ra: 3'd4, ma: 16'h1234});
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("second_xfer_reg", regAdd, 5);
    chk("second_xfer_mem", memAdd, 16'h1235);
    exp_q.delete();
    reset = 1'b0;
    #1;
    chk("abort_outputs", {busy, regAdd, memAdd, regWrite, memWrite, pcWrite, done}, 0);
    #3 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stay_idle", {busy, regWrite, memWrite, done}, 0);
    end
    run_seq(1'b1, 8'h81, 16'hABCD, 32'd0, 1'b0, 1'b0);

    // Randomized sequences
    for (int k = 0; k < 150; k++) begin
      logic [7:0] l;
      l = 8'($urandom);
      run_seq(1'($urandom), l, 16'($urandom), 32'd0, 1'b1, (l != 8'd0) && ($urandom_range(0, 1) == 1));
    end

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lm_sm_sequencer.md
# lm_sm_sequencer

Multi-cycle sequencer for the load-multiple (LM) and store-multiple (SM) instructions. It accepts an 8-bit register list and a base memory address and steps through the set bits, lowest first, one transfer per cycle. Each cycle it drives the register-file address (`regAdd`) and the matching word address (`memAdd`). It sits directly upstream of the register file and data memory: it feeds the register file's write address and write strobe for LM, and its read address for SM. The pipeline is stalled while `busy` is high.

## Interface
- No parameters; data width fixed at 16, register index at 3, list at 8.
- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-low reset
- `start`  input  1  launch a sequence; sampled only in IDLE
- `isLoad`  input  1  1 = LM (memory→registers), 0 = SM (registers→memory); latched with `start`
- `regList`  input  8  bit i set = transfer register Ri; latched with `start`
- `baseAddr`  input  16  memory address of first transfer; latched with `start`
- `hold`  input  1  memory-not-ready stall; freezes sequencer
- `busy`  output  1  high whenever state ≠ IDLE
- `regAdd`  output  3  register index of current transfer (to register-file write address for LM, read address for SM)
- `memAdd`  output  16  memory word address of current transfer
- `regWrite`  output  1  register-file write strobe (LM transfers only)
- `memWrite`  output  1  data-memory write strobe (SM transfers only)
- `pcWrite`  output  1  current LM transfer targets R7; control must flush after `done`
- `done`  output  1  one-cycle completion pulse

## Operation
- State register: IDLE, XFER, DONE.
- Internal registers: `pending[7:0]`, `offset[3:0]`, `base[15:0]`, `load`.
- IDLE: when `start`=1, latch `pending`←`regList`, `base`←`baseAddr`, `load`←`isLoad`, and `offset`←0.
  - If `regList`≠0, go to XFER; if `regList`=0, go to DONE.
- XFER:
  - `regAdd` = index of lowest set bit of `pending` (combinational priority encode).
  - `memAdd` = `base` + `offset`, 16-bit add, wraps modulo 2^16 (0xFFFF+1 → 0x0000).
  - If `hold`=0: clear that bit of `pending` and increment `offset` at the clock edge.
  - If the cleared bit was the last set bit, go to DONE; otherwise stay in XFER.
  - If `hold`=1: all registers keep their values and both write strobes are 0.
- Write strobes:
  - `regWrite` = XFER & `load` & ~`hold`.
  - `memWrite` = XFER & ~`load` & ~`hold`.
  - `pcWrite` = `regWrite` & (`regAdd`=7).
- DONE: `done`=1 for exactly one cycle, then go to IDLE unconditionally; `hold` is ignored.
- `start` is ignored while `busy`=1; no queuing.
- Outside XFER, `regAdd` and `memAdd` are 0.

## Timing
- Reset (asynchronous, `reset`=0):
  - state←IDLE, `pending`←0, `offset`←0, `base`←0, `load`←0.
  - Every output is 0: `busy`, `regAdd`, `memAdd`, `regWrite`, `memWrite`, `pcWrite`, `done`.
  - Reset asserted mid-sequence aborts it immediately; no further strobes; the sequencer restarts only on a new `start`.
- `start` sampled at edge k → XFER (or DONE) from cycle k+1; `busy` rises in cycle k+1.
- N set bits with no `hold`: transfers occupy cycles k+1 … k+N; `done` in cycle k+N+1; `busy` falls in cycle k+N+2.
- Empty list: `done` in cycle k+1, zero transfers, `busy` high for one cycle.
- Each `hold` cycle during XFER extends the sequence by exactly one cycle.
- Outputs are combinational from registered state plus `hold`; the register file and memory capture on the edge that ends the transfer cycle.
- A new `start` is accepted in the cycle `busy` returns to 0; back-to-back sequences therefore have a one-cycle IDLE gap.

## Test plan
- LM, `regList`=0x25, `baseAddr`=0x0100, no hold → `regWrite` for 3 cycles with (`regAdd`,`memAdd`) = (0,0x0100), (2,0x0101), (5,0x0102); `done` in 4th cycle after `start`; `memWrite` never 1.
- SM, `regList`=0xFF, `baseAddr`=0xFFFE → 8 `memWrite` cycles with `regAdd` 0…7 and `memAdd` 0xFFFE, 0xFFFF, 0x0000 … 0x0005; `pcWrite`=0 throughout.
- LM, `regList`=0x80, `baseAddr`=0x0040 → single transfer with `regAdd`=7, `memAdd`=0x0040, `regWrite`=1, `pcWrite`=1; `done` the next cycle.
- `regList`=0x00 with `start` → no strobes; `done` and `busy` high for the single cycle after `start`.
- SM, `regList`=0x06, `hold` high for 2 cycles during the first transfer → `regAdd`=1/`memAdd`=`base` held for 3 cycles with `memWrite` only in the third; `done` 5 cycles after `start`; a `start` pulsed mid-sequence is ignored.
- LM, `regList`=0xF0; assert `reset`=0 during the second transfer → all outputs 0 immediately; after release, stays IDLE until a new `start`.
